sys_ram_dp: RTL and testbench



---
 rtl/sys_ram_pkg.sv | 37 +++
 rtl/sys_ram_rd_pipe.sv | 68 ++++++
 rtl/sys_ram_dp.sv | 136 +++++++++++++
 tb/tb_sys_ram_dp.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ram_pkg.sv
// ---------------------------------------------------------------------------
// sys_ram_pkg
// Shared definitions for the dual-port system RAM.
//   BYTE_W        : width of one byte lane
//   byte_t        : one byte lane
//   byte_merge    : picks the new or the old byte of one lane by its enable
//   collide_merge : resolves one lane when both ports write the same word;
//                   port 1 owns every lane it enables, port 2 fills the rest
// ---------------------------------------------------------------------------
package sys_ram_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    function automatic byte_t byte_merge(input byte_t old_byte,
                                         input byte_t new_byte,
                                         input logic  en);
        return en ? new_byte : old_byte;
    endfunction

    function automatic byte_t collide_merge(input byte_t old_byte,
                                            input byte_t s1_byte,
                                            input logic  s1_en,
                                            input byte_t s2_byte,
                                            input logic  s2_en);
        byte_t result;
        result = old_byte;
        if (s1_en) begin
            result = s1_byte;
        end else if (s2_en) begin
            result = s2_byte;
        end
        return result;
    endfunction

endpackage

// File: rtl/sys_ram_rd_pipe.sv
// ---------------------------------------------------------------------------
// sys_ram_rd_pipe
// Read-return pipeline of one RAM port, LATENCY (1 or 2) stages deep.
//   clk, reset : clock and synchronous active-high reset (clears all stages)
//   clken      : stages advance only while high, otherwise they hold
//   in_valid   : a read was accepted this cycle
//   in_data    : word returned for that read (already forwarded/merged)
//   out_valid  : readdatavalid towards the master
//   out_data   : readdata towards the master
// Data registers only load alongside a valid beat, so readdata keeps the
// last returned word between reads.
// ---------------------------------------------------------------------------
module sys_ram_rd_pipe #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic              stage_valid;
    logic [DATA_W-1:0] stage_data;

    // First stage: captures the array/forwarding output at the accepting edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else if (clken) begin
            stage_valid <= in_valid;
            if (in_valid) begin
                stage_data <= in_data;
            end
        end
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            logic              out_valid_q;
            logic [DATA_W-1:0] out_data_q;

            // Second stage: output register behind the array-output register.
            always_ff @(posedge clk) begin
                if (reset) begin
                    out_valid_q <= 1'b0;
                    out_data_q  <= '0;
                end else if (clken) begin
                    out_valid_q <= stage_valid;
                    if (stage_valid) begin
                        out_data_q <= stage_data;
                    end
                end
            end

            assign out_valid = out_valid_q;
            assign out_data  = out_data_q;
        end else begin : g_lat1
            assign out_valid = stage_valid;
            assign out_data  = stage_data;
        end
    endgenerate

endmodule

// File: rtl/sys_ram_dp.sv
// ---------------------------------------------------------------------------
// sys_ram_dp
// True dual-port on-chip RAM behind two Avalon-MM slave ports.
//   clk, reset, clken      : clock, synchronous active-high reset, global enable
//   s1_* / s2_*            : chipselect, read, write, word address, byteenable,
//                            writedata in; readdata, readdatavalid out
// Collision behaviour:
//   - same port read+write : read returns the freshly written word (write-first)
//   - cross-port           : a read sees the word before the other port's write
//   - double write         : s1 wins per enabled lane, s2 fills the remaining lanes
// Addresses >= DEPTH ignore writes and read back as zero.
// ---------------------------------------------------------------------------
module sys_ram_dp
    import sys_ram_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 15,
    parameter int DEPTH        = 32768,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clken,
    input  logic                 s1_chipselect,
    input  logic                 s1_read,
    input  logic                 s1_write,
    input  logic [ADDR_W-1:0]    s1_address,
    input  logic [DATA_W/8-1:0]  s1_byteenable,
    input  logic [DATA_W-1:0]    s1_writedata,
    output logic [DATA_W-1:0]    s1_readdata,
    output logic                 s1_readdatavalid,
    input  logic                 s2_chipselect,
    input  logic                 s2_read,
    input  logic                 s2_write,
    input  logic [ADDR_W-1:0]    s2_address,
    input  logic [DATA_W/8-1:0]  s2_byteenable,
    input  logic [DATA_W-1:0]    s2_writedata,
    output logic [DATA_W-1:0]    s2_readdata,
    output logic                 s2_readdatavalid
);

    localparam int              NB      = DATA_W / BYTE_W;
    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              s1_rd_acc, s1_wr_acc, s2_rd_acc, s2_wr_acc;
    logic              s1_in, s2_in, s1_wr_ok, s2_wr_ok, collide;
    logic [IDX_W-1:0]  s1_idx, s2_idx;
    logic [DATA_W-1:0] s1_old, s2_old, s1_merge, s2_merge, col_word;
    logic [DATA_W-1:0] s1_rd_word, s2_rd_word;

    assign s1_rd_acc = s1_chipselect & s1_read  & clken & ~reset;
    assign s1_wr_acc = s1_chipselect & s1_write & clken & ~reset;
    assign s2_rd_acc = s2_chipselect & s2_read  & clken & ~reset;
    assign s2_wr_acc = s2_chipselect & s2_write & clken & ~reset;

    assign s1_in  = ({1'b0, s1_address} < DEPTH_V);
    assign s2_in  = ({1'b0, s2_address} < DEPTH_V);
    assign s1_idx = s1_address[IDX_W-1:0];
    assign s2_idx = s2_address[IDX_W-1:0];

    assign s1_wr_ok = s1_wr_acc & s1_in;
    assign s2_wr_ok = s2_wr_acc & s2_in;
    assign collide  = s1_wr_ok & s2_wr_ok & (s1_idx == s2_idx);

    // Old words, per-port merged write words and the double-write word.
    // Out-of-range addresses read as zero and never write, so the guarded
    // array read is never used for them.
    always_comb begin
        s1_old = '0;
        s2_old = '0;
        if (s1_in) s1_old = mem[s1_idx];
        if (s2_in) s2_old = mem[s2_idx];
        s1_merge = s1_old;
        s2_merge = s2_old;
        col_word = s1_old;
        for (int b = 0; b < NB; b++) begin
            s1_merge[b*BYTE_W +: BYTE_W] = byte_merge(s1_old[b*BYTE_W +: BYTE_W],
                                                      s1_writedata[b*BYTE_W +: BYTE_W],
                                                      s1_byteenable[b]);
            s2_merge[b*BYTE_W +: BYTE_W] = byte_merge(s2_old[b*BYTE_W +: BYTE_W],
                                                      s2_writedata[b*BYTE_W +: BYTE_W],
                                                      s2_byteenable[b]);
            col_word[b*BYTE_W +: BYTE_W] = collide_merge(s1_old[b*BYTE_W +: BYTE_W],
                                                         s1_writedata[b*BYTE_W +: BYTE_W],
                                                         s1_byteenable[b],
                                                         s2_writedata[b*BYTE_W +: BYTE_W],
                                                         s2_byteenable[b]);
        end
    end

    // Own-port write is forwarded into the read (write-first); the other
    // port's write in the same cycle is not visible (read-first).
    assign s1_rd_word = s1_wr_ok ? s1_merge : s1_old;
    assign s2_rd_word = s2_wr_ok ? s2_merge : s2_old;

    // Array update. On a double write to one word only the s1 path writes,
    // carrying the lane-resolved word so both ports never hit one entry.
    always_ff @(posedge clk) begin
        if (s1_wr_ok) begin
            mem[s1_idx] <= collide ? col_word : s1_merge;
        end
        if (s2_wr_ok && !collide) begin
            mem[s2_idx] <= s2_merge;
        end
    end

    sys_ram_rd_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe1 (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .in_valid  (s1_rd_acc),
        .in_data   (s1_rd_word),
        .out_valid (s1_readdatavalid),
        .out_data  (s1_readdata)
    );

    sys_ram_rd_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe2 (
        .clk       (clk),
        .reset     (reset),
        .clken     (clken),
        .in_valid  (s2_rd_acc),
        .in_data   (s2_rd_word),
        .out_valid (s2_readdatavalid),
        .out_data  (s2_readdata)
    );

endmodule

// File: tb/tb_sys_ram_dp.sv
// ---------------------------------------------------------------------------
// tb_sys_ram_dp
// Drives two RAM instances with identical stimulus: dutA uses the default
// geometry with one cycle of read latency, dutB has DEPTH=1000 and two
// cycles of latency. A word-level reference memory with a queue of pending
// read returns per port predicts readdatavalid/readdata for both.
// ---------------------------------------------------------------------------
module tb_sys_ram_dp;

   localparam int DEPTH_A = 32768;
   localparam int LAT_A   = 1;
   localparam int DEPTH_B = 1000;
   localparam int LAT_B   = 2;

   logic        clk = 1'b0;
   logic        reset, clken;
   logic        s1Cs, s1Rd, s1Wr, s2Cs, s2Rd, s2Wr;
   logic [14:0] s1Addr, s2Addr;
   logic [3:0]  s1Be, s2Be;
   logic [31:0] s1Wd, s2Wd;
   logic [31:0] aS1Rd, aS2Rd, bS1Rd, bS2Rd;
   logic        aS1V, aS2V, bS1V, bS2V;

   typedef struct {
      int          due;
      logic [31:0] data;
   } pend_t;

   pend_t       pendQ [4][$];
   logic [31:0] mdl [2][1024];
   logic        expV [4];
   logic [31:0] expD [4];
   logic        obsV [4];
   logic [31:0] obsD [4];
   logic [31:0] lastD [4];
   int          clkenCount;
   int          testsRun;
   int          testsFailed;

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   sys_ram_dp #(.DATA_W(32), .ADDR_W(15), .DEPTH(DEPTH_A), .READ_LATENCY(LAT_A)) dutA (
      .clk(clk), .reset(reset), .clken(clken),
      .s1_chipselect(s1Cs), .s1_read(s1Rd), .s1_write(s1Wr), .s1_address(s1Addr),
      .s1_byteenable(s1Be), .s1_writedata(s1Wd), .s1_readdata(aS1Rd), .s1_readdatavalid(aS1V),
      .s2_chipselect(s2Cs), .s2_read(s2Rd), .s2_write(s2Wr), .s2_address(s2Addr),
      .s2_byteenable(s2Be), .s2_writedata(s2Wd), .s2_readdata(aS2Rd), .s2_readdatavalid(aS2V));

   sys_ram_dp #(.DATA_W(32), .ADDR_W(15), .DEPTH(DEPTH_B), .READ_LATENCY(LAT_B)) dutB (
      .clk(clk), .reset(reset), .clken(clken),
      .s1_chipselect(s1Cs), .s1_read(s1Rd), .s1_write(s1Wr), .s1_address(s1Addr),
      .s1_byteenable(s1Be), .s1_writedata(s1Wd), .s1_readdata(bS1Rd), .s1_readdatavalid(bS1V),
      .s2_chipselect(s2Cs), .s2_read(s2Rd), .s2_write(s2Wr), .s2_address(s2Addr),
      .s2_byteenable(s2Be), .s2_writedata(s2Wd), .s2_readdata(bS2Rd), .s2_readdatavalid(bS2V));

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Word seen by a read: zero out of range, else the stored word with this
   // port's own enabled write bytes laid over it.
   function automatic logic [31:0] portRead(input bit dSel, input int depth, input logic [14:0] a,
                                            input logic ownWr, input logic [3:0] be, input logic [31:0] wd);
      logic [31:0] w;
      if (int'(a) >= depth) return 32'h0;
      w = mdl[dSel][a[9:0]];
      if (ownWr) begin
         for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      end
      return w;
   endfunction

   task automatic laneWrite(input bit dSel, input logic [14:0] a, input logic [3:0] be, input logic [31:0] wd);
      for (int b = 0; b < 4; b++) if (be[b]) mdl[dSel][a[9:0]][b*8 +: 8] = wd[b*8 +: 8];
   endtask

   // Reference model step for one rising edge.
   task automatic modelStep();
      int          depth, lat;
      bit          dSel;
      logic [31:0] rd;
      if (reset) begin
         for (int i = 0; i < 4; i++) begin
            pendQ[i].delete();
            expV[i] = 1'b0;
            expD[i] = 32'h0;
         end
         return;
      end
      if (!clken) return;
      clkenCount++;
      for (int d = 0; d < 2; d++) begin
         dSel  = d[0];
         depth = (d == 0) ? DEPTH_A : DEPTH_B;
         lat   = (d == 0) ? LAT_A : LAT_B;
         if (s1Cs && s1Rd) begin
            rd = portRead(dSel, depth, s1Addr, s1Cs && s1Wr, s1Be, s1Wd);
            pendQ[2*d].push_back('{due: clkenCount + lat - 1, data: rd});
         end
         if (s2Cs && s2Rd) begin
            rd = portRead(dSel, depth, s2Addr, s2Cs && s2Wr, s2Be, s2Wd);
            pendQ[2*d+1].push_back('{due: clkenCount + lat - 1, data: rd});
         end
         if (s2Cs && s2Wr && int'(s2Addr) < depth) laneWrite(dSel, s2Addr, s2Be, s2Wd);
         if (s1Cs && s1Wr && int'(s1Addr) < depth) laneWrite(dSel, s1Addr, s1Be, s1Wd);
      end
      for (int i = 0; i < 4; i++) begin
         if (pendQ[i].size() > 0 && pendQ[i][0].due == clkenCount) begin
            expV[i] = 1'b1;
            expD[i] = pendQ[i][0].data;
            void'(pendQ[i].pop_front());
         end else begin
            expV[i] = 1'b0;
         end
      end
   endtask

   task automatic compareOutputs();
      obsV[0] = aS1V; obsD[0] = aS1Rd;
      obsV[1] = aS2V; obsD[1] = aS2Rd;
      obsV[2] = bS1V; obsD[2] = bS1Rd;
      obsV[3] = bS2V; obsD[3] = bS2Rd;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("valid%0d", i), {31'b0, obsV[i]}, {31'b0, expV[i]});
         if (expV[i] || reset) checkOutput($sformatf("data%0d", i), obsD[i], expD[i]);
         if (obsV[i]) lastD[i] = obsD[i];
      end
   endtask

   // Drive one cycle of inputs, advance the clock, update model, check.
   task automatic applyStimulus(input logic rst, input logic ck,
                                input logic c1, input logic r1, input logic w1, input logic [14:0] a1,
                                input logic [3:0] b1, input logic [31:0] d1,
                                input logic c2, input logic r2, input logic w2, input logic [14:0] a2,
                                input logic [3:0] b2, input logic [31:0] d2);
      reset = rst; clken = ck;
      s1Cs = c1; s1Rd = r1; s1Wr = w1; s1Addr = a1; s1Be = b1; s1Wd = d1;
      s2Cs = c2; s2Rd = r2; s2Wr = w2; s2Addr = a2; s2Be = b2; s2Wd = d2;
      @(posedge clk);
      modelStep();
      #1;
      compareOutputs();
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
   endtask

   task automatic clearLast();
      for (int i = 0; i < 4; i++) lastD[i] = 32'hA5A5A5A5;
   endtask

   function automatic logic [14:0] pickAddr();
      int sel;
      sel = $urandom_range(0, 3);
      if (sel < 2) return 15'($urandom_range(0, 7));
      if (sel == 2) return 15'($urandom_range(990, 1023));
      return 15'($urandom_range(0, 1023));
   endfunction

   initial begin
      logic        rRst, rCk, rC1, rR1, rW1, rC2, rR2, rW2;
      logic [3:0]  rB1, rB2;
      logic [31:0] rD1, rD2;
      testsRun = 0; testsFailed = 0; clkenCount = 0;
      for (int d = 0; d < 2; d++) for (int a = 0; a < 1024; a++) mdl[d][a] = 32'h0;
      for (int i = 0; i < 4; i++) begin expV[i] = 1'b0; expD[i] = 32'h0; end
      clearLast();

      // Reset, then clear the low 1024 words so every checked word is known.
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 15'h5, 4'hF, 32'h1, 1'b1, 1'b1, 1'b0, 15'h5, 4'h0, 32'h0);
      for (int a = 0; a < 1024; a++)
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15'(a), 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);

      // s1 write then s2 read of 0x10.
      clearLast();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15'h10, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 15'h10, 4'h0, 32'h0);
      checkOutput("tp1ValidA", {31'b0, aS2V}, 32'h1);
      checkOutput("tp1EarlyB", {31'b0, bS2V}, 32'h0);
      idle();
      checkOutput("tp1PulseA", {31'b0, aS2V}, 32'h0);
      checkOutput("tp1ValidB", {31'b0, bS2V}, 32'h1);
      idle();
      checkOutput("tp1DataA", lastD[1], 32'hDEADBEEF);
      checkOutput("tp1DataB", lastD[3], 32'hDEADBEEF);

      // Partial byte-enable write.
      clearLast();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15'h20, 4'hF, 32'h11223344, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15'h20, 4'h5, 32'hAABBCCDD, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'h20, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
      idle(); idle();
      checkOutput("tp2DataA", lastD[0], 32'h11BB33DD);
      checkOutput("tp2DataB", lastD[2], 32'h11BB33DD);

      // Double write to one word: s1 owns its enabled lanes.
      clearLast();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15'h30, 4'hC, 32'hFFFF0000, 1'b1, 1'b0, 1'b1, 15'h30, 4'hF, 32'h0000AAAA);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 15'h30, 4'h0, 32'h0);
      idle(); idle();
      checkOutput("tp3DataA", lastD[1], 32'hFFFFAAAA);
      checkOutput("tp3DataB", lastD[3], 32'hFFFFAAAA);

      // s1 read+write with s2 read of the same word.
      clearLast();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 15'h40, 4'hF, 32'h12345678, 1'b1, 1'b1, 1'b0, 15'h40, 4'h0, 32'h0);
      idle(); idle();
      checkOutput("tp4OwnA", lastD[0], 32'h12345678);
      checkOutput("tp4CrossA", lastD[1], 32'h0);
      checkOutput("tp4OwnB", lastD[2], 32'h12345678);
      checkOutput("tp4CrossB", lastD[3], 32'h0);

      // Back-to-back reads with one clken-low cycle, then reset mid-flight.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'h10, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'h20, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 15'h30, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'h30, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'h40, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
      idle(); idle();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'h10, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 15'h20, 4'h0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 15'h20, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
      idle(); idle(); idle();

      // Depth boundary on dutB.
      clearLast();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15'd999, 4'hF, 32'h00000077, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 15'd1000, 4'hF, 32'h00000005, 1'b0, 1'b0, 1'b0, 15'h0, 4'h0, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 15'd1000, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 15'd999, 4'h0, 32'h0);
      idle(); idle();
      checkOutput("tp6HighA", lastD[0], 32'h5);
      checkOutput("tp6HighB", lastD[2], 32'h0);
      checkOutput("tp6EdgeA", lastD[1], 32'h77);
      checkOutput("tp6EdgeB", lastD[3], 32'h77);

      // Randomized traffic biased towards a few hot addresses.
      for (int n = 0; n < 3000; n++) begin
         rRst = 1'($urandom_range(0, 99) == 0);
         rCk  = 1'($urandom_range(0, 9) != 0);
         rC1  = 1'($urandom_range(0, 3) != 0);
         rR1  = 1'($urandom_range(0, 1));
         rW1  = 1'($urandom_range(0, 1));
         rB1  = 4'($urandom_range(0, 15));
         rD1  = $urandom;
         rC2  = 1'($urandom_range(0, 3) != 0);
         rR2  = 1'($urandom_range(0, 1));
         rW2  = 1'($urandom_range(0, 1));
         rB2  = 4'($urandom_range(0, 15));
         rD2  = $urandom;
         applyStimulus(rRst, rCk, rC1, rR1, rW1, pickAddr(), rB1, rD1, rC2, rR2, rW2, pickAddr(), rB2, rD2);
      end
      idle(); idle(); idle();

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
